// File: rtl/wb_register_file.sv
// ---------------------------------------------------------------------------
// wb_register_file
//
// Write-back stage and architectural register file of the five-stage
// pipeline. It commits write-back results into eight 16-bit general
// registers (R0-R7), the stack pointer and the registered output port.
// It serves two combinational read ports to the decode stage, and it keeps a
// free-running 16-bit count of committed write-back cycles for debug.
//
// Optional feature: define WB_BYPASS_EN to forward a same-cycle REG_WRITE
// result onto any read port whose address matches the destination index.
// Left undefined, read ports always show stored contents.
//
// Parameters:
//   NUMBER_CONTROL_SIGNALS  width of the control bus (>= 3)
//   SP_RESET                stack pointer value after reset
//
// Ports:
//   clk                 in   rising-edge clock
//   reset               in   asynchronous active-low reset
//   control_signals_IN  in   bit0 REG_WRITE, bit1 SP_WRITE, bit2 OUT_WRITE
//   result_IN           in   value for a general register / output port
//   reg_dst_num_IN      in   destination general register index
//   sp_IN               in   new stack pointer value
//   rd_addr_a/b         in   read port indices
//   rd_data_a/b         out  read port data
//   sp_OUT              out  current stack pointer
//   out_port            out  registered output port
//   wb_count            out  committed write-back cycle count (wraps)
// ---------------------------------------------------------------------------
module wb_register_file #(
    parameter int          NUMBER_CONTROL_SIGNALS = 5,
    parameter logic [15:0] SP_RESET               = 16'h03FF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUMBER_CONTROL_SIGNALS-1:0] control_signals_IN,
    input  logic [15:0]                       result_IN,
    input  logic [2:0]                        reg_dst_num_IN,
    input  logic [15:0]                       sp_IN,
    input  logic [2:0]                        rd_addr_a,
    output logic [15:0]                       rd_data_a,
    input  logic [2:0]                        rd_addr_b,
    output logic [15:0]                       rd_data_b,
    output logic [15:0]                       sp_OUT,
    output logic [15:0]                       out_port,
    output logic [15:0]                       wb_count
);

    logic [15:0] r_regs [8];
    logic [15:0] r_sp;
    logic [15:0] r_out_port;
    logic [15:0] r_wb_count;

    logic w_reg_write;
    logic w_sp_write;
    logic w_out_write;
    logic w_any_write;

    assign w_reg_write = control_signals_IN[0];
    assign w_sp_write  = control_signals_IN[1];
    assign w_out_write = control_signals_IN[2];
    assign w_any_write = w_reg_write | w_sp_write | w_out_write;

    // Reserved control bits carry no meaning here; collect them so they are
    // visibly consumed.
    generate
        if (NUMBER_CONTROL_SIGNALS > 3) begin : g_reserved
            logic w_unused_ctrl;
            assign w_unused_ctrl = ^control_signals_IN[NUMBER_CONTROL_SIGNALS-1:3];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 16'h0000;
            end
            r_sp       <= SP_RESET;
            r_out_port <= 16'h0000;
            r_wb_count <= 16'h0000;
        end else begin
            if (w_reg_write) begin
                r_regs[reg_dst_num_IN] <= result_IN;
            end
            if (w_sp_write) begin
                r_sp <= sp_IN;
            end
            if (w_out_write) begin
                r_out_port <= result_IN;
            end
            // Natural 16-bit rollover gives the silent wrap.
            if (w_any_write) begin
                r_wb_count <= r_wb_count + 16'd1;
            end
        end
    end

`ifdef WB_BYPASS_EN
    logic w_byp_a;
    logic w_byp_b;

    // Forwarding is gated by reset so reads show the cleared array while
    // reset is held low.
    assign w_byp_a   = reset && w_reg_write && (rd_addr_a == reg_dst_num_IN);
    assign w_byp_b   = reset && w_reg_write && (rd_addr_b == reg_dst_num_IN);
    assign rd_data_a = w_byp_a ? result_IN : r_regs[rd_addr_a];
    assign rd_data_b = w_byp_b ? result_IN : r_regs[rd_addr_b];
`else
    assign rd_data_a = r_regs[rd_addr_a];
    assign rd_data_b = r_regs[rd_addr_b];
`endif

    assign sp_OUT   = r_sp;
    assign out_port = r_out_port;
    assign wb_count = r_wb_count;

endmodule

// File: tb/tb_wb_register_file.sv
module tb_wb_register_file;

    logic        clk;
    logic        reset;
    logic [4:0]  control_signals_IN;
    logic [15:0] result_IN;
    logic [2:0]  reg_dst_num_IN;
    logic [15:0] sp_IN;
    logic [2:0]  rd_addr_a;
    logic [15:0] rd_data_a;
    logic [2:0]  rd_addr_b;
    logic [15:0] rd_data_b;
    logic [15:0] sp_OUT;
    logic [15:0] out_port;
    logic [15:0] wb_count;

    int n_checks = 0;
    int n_fails  = 0;

    logic [15:0] exp_regs [8];

    wb_register_file #(
        .NUMBER_CONTROL_SIGNALS(5),
        .SP_RESET(16'h03FF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .control_signals_IN(control_signals_IN),
        .result_IN(result_IN),
        .reg_dst_num_IN(reg_dst_num_IN),
        .sp_IN(sp_IN),
        .rd_addr_a(rd_addr_a),
        .rd_data_a(rd_data_a),
        .rd_addr_b(rd_addr_b),
        .rd_data_b(rd_data_b),
        .sp_OUT(sp_OUT),
        .out_port(out_port),
        .wb_count(wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; sampling and driving happen here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            rd_addr_b = 3'(7 - i);
            #1;
            check($sformatf("%s_a_R%0d", tag, i), rd_data_a, exp_regs[i]);
            check($sformatf("%s_b_R%0d", tag, 7 - i), rd_data_b, exp_regs[7 - i]);
        end
    endtask

    initial begin
        reset              = 1'b0;
        control_signals_IN = 5'b0;
        result_IN          = 16'h0;
        reg_dst_num_IN     = 3'd0;
        sp_IN              = 16'h0;
        rd_addr_a          = 3'd0;
        rd_addr_b          = 3'd0;
        for (int i = 0; i < 8; i++) exp_regs[i] = 16'h0;

        tick();
        tick();
        check("por_sp", sp_OUT, 16'h03FF);
        check("por_count", wb_count, 16'h0000);
        #2 reset = 1'b1;
        tick();

        // Put non-reset state everywhere, then reset mid-cycle with a write pending.
        control_signals_IN = 5'b00111;
        reg_dst_num_IN     = 3'd3;
        result_IN          = 16'h1111;
        sp_IN              = 16'h1000;
        tick();
        rd_addr_a = 3'd3;
        #1;
        check("pre_rst_R3", rd_data_a, 16'h1111);
        check("pre_rst_count", wb_count, 16'h0001);
        control_signals_IN = 5'b00001;
        result_IN          = 16'hBEEF;
        #1 reset = 1'b0;
        #1;
        check("rst_sp", sp_OUT, 16'h03FF);
        check("rst_out", out_port, 16'h0000);
        check("rst_count", wb_count, 16'h0000);
        check_all_regs("rst");
        tick();
        check("rst_edge_R3", rd_data_b, 16'h0000);
        rd_addr_a = 3'd3;
        #1;
        check("rst_hold_R3", rd_data_a, 16'h0000);
        control_signals_IN = 5'b0;
        #1 reset = 1'b1;
        tick();
        check("rel_R3", rd_data_a, 16'h0000);
        check("rel_count", wb_count, 16'h0000);

        // Basic write/read.
        control_signals_IN = 5'b00001;
        reg_dst_num_IN     = 3'd5;
        result_IN          = 16'h1234;
        tick();
        reg_dst_num_IN = 3'd2;
        result_IN      = 16'hABCD;
        tick();
        control_signals_IN = 5'b0;
        rd_addr_a = 3'd5;
        rd_addr_b = 3'd2;
        #1;
        check("basic_a_R5", rd_data_a, 16'h1234);
        check("basic_b_R2", rd_data_b, 16'hABCD);
        check("basic_count", wb_count, 16'h0002);
        rd_addr_b = 3'd5;
        #1;
        check("same_a_R5", rd_data_a, 16'h1234);
        check("same_b_R5", rd_data_b, 16'h1234);

        // All three controls in one cycle.
        control_signals_IN = 5'b00111;
        reg_dst_num_IN     = 3'd7;
        result_IN          = 16'h00FF;
        sp_IN              = 16'h03FD;
        tick();
        control_signals_IN = 5'b0;
        rd_addr_a = 3'd7;
        #1;
        check("simul_R7", rd_data_a, 16'h00FF);
        check("simul_sp", sp_OUT, 16'h03FD);
        check("simul_out", out_port, 16'h00FF);
        check("simul_count", wb_count, 16'h0003);

        // Same-cycle decode/write-back hazard on R4.
        control_signals_IN = 5'b00001;
        reg_dst_num_IN     = 3'd4;
        result_IN          = 16'h0001;
        tick();
        result_IN = 16'h0002;
        rd_addr_a = 3'd4;
        #1;
`ifdef WB_BYPASS_EN
        check("hazard_before", rd_data_a, 16'h0002);
`else
        check("hazard_before", rd_data_a, 16'h0001);
`endif
        tick();
        control_signals_IN = 5'b0;
        #1;
        check("hazard_after", rd_data_a, 16'h0002);
        check("hazard_count", wb_count, 16'h0005);

        // Idle cycles: reserved bits and data toggle, no write bits set.
        for (int i = 0; i < 100; i++) begin
            control_signals_IN = {2'($urandom_range(0, 3)), 3'b000};
            result_IN          = 16'($urandom);
            reg_dst_num_IN     = 3'($urandom_range(0, 7));
            sp_IN              = 16'($urandom);
            tick();
        end
        control_signals_IN = 5'b0;
        exp_regs[2] = 16'hABCD;
        exp_regs[4] = 16'h0002;
        exp_regs[5] = 16'h1234;
        exp_regs[7] = 16'h00FF;
        check_all_regs("idle");
        check("idle_sp", sp_OUT, 16'h03FD);
        check("idle_out", out_port, 16'h00FF);
        check("idle_count", wb_count, 16'h0005);

        // Counter wrap: 65531 more writes take 5 to 0.
        control_signals_IN = 5'b00001;
        reg_dst_num_IN     = 3'd1;
        for (int i = 0; i < 65530; i++) begin
            result_IN = 16'(i);
            tick();
        end
        check("wrap_ffff", wb_count, 16'hFFFF);
        result_IN = 16'h5A5A;
        tick();
        check("wrap_zero", wb_count, 16'h0000);
        result_IN = 16'hA5A5;
        tick();
        control_signals_IN = 5'b0;
        rd_addr_a = 3'd1;
        #1;
        check("wrap_one", wb_count, 16'h0001);
        check("wrap_R1", rd_data_a, 16'hA5A5);
        check("wrap_sp", sp_OUT, 16'h03FD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
